axis_buf_wr_arb: RTL and testbench
==================================

# axis_buf_wr_arb

Shares one AXI4 write port (AW/W/B) between `N_PORTS` stream-buffer write masters, such as `axis_buf` TX interfaces, ahead of the shell interconnect. AW requests are granted round-robin. Each grant's port index is queued so W bursts follow AW order. The port index is prefixed to AWID, and B responses are routed back by that prefix.

## Interface
Parameters:
- `N_PORTS`, 4: number of requesters, 2..16.
- `PL`, $clog2(N_PORTS): port-index width prefixed to IDs.
- `ID_W`, 16: requester AWID/BID width.
- `ADDR_W`, 64: address width.
- `W_FIFO_LD`, 3: log2 depth of the W-order FIFO, so 8 outstanding bursts.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `s_awvalid` / `s_awready`  in / out  N_PORTS  per-port AW handshake.
- `s_awaddr`  in  N_PORTS*ADDR_W  per-port AW address.
- `s_awlen`  in  N_PORTS*8  per-port burst length.
- `s_awsize`  in  N_PORTS*3  per-port burst size.
- `s_awid`  in  N_PORTS*ID_W  per-port AW ID.
- `s_wvalid` / `s_wready` / `s_wlast`  in / out / in  N_PORTS  per-port W handshake and last-beat flag.
- `s_wdata`  in  N_PORTS*512  per-port write data.
- `s_wstrb`  in  N_PORTS*64  per-port write strobes.
- `s_bvalid` / `s_bready`  out / in  N_PORTS  per-port B handshake.
- `s_bid`  out  ID_W  requester BID, shared across ports.
- `s_bresp`  out  2  write response, shared across ports.
- `m_awvalid`, `m_awready`, `m_awaddr`, `m_awlen`, `m_awsize`  AW channel to shell; same widths as one `s_` port.
- `m_awid`  out  PL+ID_W  equals {grant index, s_awid}.
- `m_wvalid`, `m_wready`, `m_wdata`, `m_wstrb`, `m_wlast`  W channel to shell; same widths as one `s_` port.
- `m_bvalid`, `m_bready`, `m_bresp`  B channel to shell.
- `m_bid`  in  PL+ID_W  B ID from shell; the top PL bits select the port.

## Operation
- **AW arbiter state:** `locked` (1 bit), `sel` (PL bits), `rr` (PL bits, last-granted port).
- **Unlocked:** when the W FIFO is not full, `sel` is the first port with `s_awvalid` set, scanning `rr+1, rr+2, …` modulo N_PORTS. The scan is combinational. `m_awvalid` is asserted if any port is valid.
- **Locked:** if `m_awvalid` is high and `m_awready` is low, set `locked`. `sel` then holds until the handshake, as AXI stability requires. A lower-index port asserting valid must not steal the grant.
- **Handshake:** `m_awready` && `m_awvalid` triggers, on that edge:
  - `s_awready[sel]` = 1, combinationally;
  - push `sel` into the W FIFO;
  - `rr` <= `sel`;
  - `locked` <= 0.
- **AW pass-through:** `m_awaddr`, `m_awlen`, `m_awsize` are muxed from `sel`. `m_awid` = {sel, s_awid[sel]}.
- **W FIFO full:** `m_awvalid` = 0 and all `s_awready` = 0. This applies only when the FIFO is not locked. A locked grant has already presented valid and is never withdrawn, so FIFO depth must cover that case. The push check uses registered count only: a push is refused at count = 2^W_FIFO_LD even if a pop occurs the same cycle.
- **W path, FIFO not empty (head h):**
  - `m_wvalid` = `s_wvalid[h]`; `s_wready[h]` = `m_wready`; all other `s_wready` = 0.
  - data, strb and last are muxed from h.
  - Pop on `m_wvalid` && `m_wready` && `m_wlast`.
- **W path, FIFO empty:** `m_wvalid` = 0 and all `s_wready` = 0. W data is never forwarded before its AW handshake.
- **B path:**
  - p = `m_bid[PL+ID_W-1:ID_W]`.
  - `s_bvalid[p]` = `m_bvalid`; all other `s_bvalid` = 0.
  - `m_bready` = `s_bready[p]`.
  - `s_bid` = `m_bid[ID_W-1:0]`; `s_bresp` = `m_bresp`.
  - A p value ≥ N_PORTS gives `m_bready` = 1, and the response is dropped.

## Timing
- AW grant has zero-cycle latency: `s_awvalid` to `m_awvalid` is combinational.
- W for a granted burst can start no earlier than the cycle after its AW handshake (FIFO write latency of 1).
- Back-to-back AW grants to different ports are allowed every cycle while the FIFO has space.
- The FIFO is a register array with count. Simultaneous push and pop (not full) leaves count unchanged and preserves order.
- **Reset values:** `locked` = 0, `rr` = N_PORTS-1 (port 0 scanned first), FIFO count 0. All `s_awready`, `s_wready`, `s_bvalid`, `m_awvalid`, `m_wvalid` = 0 during and after reset until inputs request. `m_bready` follows combinationally.
- **Reset mid-burst:** queued W bursts are discarded. The shell must be reset with the arbiter.

## Test plan
- **Round-robin:** ports 0..3 all hold awvalid with awlen=0, `m_awready`=1. Grants are 0,1,2,3,0; `m_awid` top bits follow the same order.
- **Lock hold:** port 2 granted, `m_awready`=0 for 5 cycles, port 0 raises awvalid in cycle 2. `m_awaddr` stays port 2's value; port 0 is granted the cycle after the handshake.
- **W ordering:** grant port 1 (awlen=3) then port 3 (awlen=0), port 3 W already valid. Port 3 `s_wready` stays 0 until port 1's 4th beat with wlast; port 3's beat follows.
- **FIFO full:** with W_FIFO_LD=3, issue 8 AWs with `m_wready`=0. The 9th sees `m_awvalid`=0. Completing one burst re-enables AW the next cycle.
- **B routing:** `m_bid`={2'd3,16'h00A5}, `m_bvalid`=1, `s_bready[3]`=0 for 2 cycles. `s_bvalid`=4'b1000, `s_bid`=16'h00A5, `m_bready`=0 then 1.
- **Reset mid-burst:** assert rst during beat 2 of a 4-beat burst. Next cycle FIFO count=0, `m_wvalid`=0, and port 0 is granted first.

Source files
------------

// File: rtl/axis_buf_wr_arb_if.sv
// AXI4 write-channel bundle (AW/W/B) for NP parallel ports.
// Ports: per-port AW/W/B handshakes plus a shared BID/BRESP; master drives requests.
interface axis_buf_wr_arb_if #(
  parameter int NP = 1,
  parameter int IW = 16,
  parameter int AW = 64
);
  logic [NP-1:0]     awvalid;
  logic [NP-1:0]     awready;
  logic [NP*AW-1:0]  awaddr;
  logic [NP*8-1:0]   awlen;
  logic [NP*3-1:0]   awsize;
  logic [NP*IW-1:0]  awid;
  logic [NP-1:0]     wvalid;
  logic [NP-1:0]     wready;
  logic [NP-1:0]     wlast;
  logic [NP*512-1:0] wdata;
  logic [NP*64-1:0]  wstrb;
  logic [NP-1:0]     bvalid;
  logic [NP-1:0]     bready;
  logic [IW-1:0]     bid;
  logic [1:0]        bresp;

  modport master (
    output awvalid, awaddr, awlen, awsize, awid,
    output wvalid, wdata, wstrb, wlast, bready,
    input  awready, wready, bvalid, bid, bresp
  );

  modport slave (
    input  awvalid, awaddr, awlen, awsize, awid,
    input  wvalid, wdata, wstrb, wlast, bready,
    output awready, wready, bvalid, bid, bresp
  );
endinterface

// File: rtl/axis_buf_wr_arb.sv
// Round-robin arbiter sharing one AXI4 write port among N_PORTS masters.
// Ports: clk, rst (sync, active-high), s (N-port slave side), m (shell master side).
module axis_buf_wr_arb #(
  parameter int N_PORTS   = 4,
  parameter int PL        = $clog2(N_PORTS),
  parameter int ID_W      = 16,
  parameter int ADDR_W    = 64,
  parameter int W_FIFO_LD = 3
) (
  input logic clk,
  input logic rst,
  axis_buf_wr_arb_if.slave  s,
  axis_buf_wr_arb_if.master m
);
  localparam int D = 1 << W_FIFO_LD;

  logic          locked_q, locked_d;
  logic [PL-1:0] rr_q, rr_d;
  logic [PL-1:0] sel_q, sel_d;
  logic [PL-1:0] scan_sel, sel;
  logic          awv, hs;

  logic [PL-1:0]        fifo_q [D];
  logic [W_FIFO_LD-1:0] wp_q, rp_q;
  logic [W_FIFO_LD:0]   cnt_q;
  logic                 full, w_en, push, pop;
  logic [PL-1:0]        h;
  logic [PL-1:0]        p;

  assign full = (cnt_q == (W_FIFO_LD+1)'(D));
  assign w_en = !rst && (cnt_q != '0);
  assign h    = fifo_q[rp_q];
  assign push = hs && !full;
  assign pop  = m.wvalid[0] && m.wready[0] && m.wlast[0];
  assign p    = m.bid[PL+ID_W-1:ID_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      locked_q <= 1'b0;
      rr_q     <= PL'(N_PORTS-1);
      sel_q    <= '0;
    end else begin
      locked_q <= locked_d;
      rr_q     <= rr_d;
      sel_q    <= sel_d;
    end
  end

  always_comb begin : aw_next
    logic [PL-1:0] idx;
    idx      = '0;
    scan_sel = '0;
    // Descending scan: the last hit is the nearest port after rr.
    for (int i = N_PORTS; i >= 1; i--) begin
      idx = PL'((int'(rr_q) + i) % N_PORTS);
      if (s.awvalid[idx]) scan_sel = idx;
    end
    sel = locked_q ? sel_q : scan_sel;
    // A locked grant stays valid even if the FIFO filled meanwhile.
    awv = !rst && (locked_q || ((|s.awvalid) && !full));
    hs  = awv && m.awready[0];
    locked_d = locked_q;
    rr_d     = rr_q;
    sel_d    = sel_q;
    if (hs) begin
      locked_d = 1'b0;
      rr_d     = sel;
    end else if (awv) begin
      locked_d = 1'b1;
      sel_d    = sel;
    end
  end

  always_comb begin : aw_out
    m.awvalid = awv;
    m.awaddr  = '0;
    m.awlen   = '0;
    m.awsize  = '0;
    m.awid    = '0;
    s.awready = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (sel == PL'(i)) begin
        m.awaddr     = s.awaddr[i*ADDR_W +: ADDR_W];
        m.awlen      = s.awlen[i*8 +: 8];
        m.awsize     = s.awsize[i*3 +: 3];
        m.awid       = {sel, s.awid[i*ID_W +: ID_W]};
        s.awready[i] = hs;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + W_FIFO_LD'(1);
      if (pop)  rp_q <= rp_q + W_FIFO_LD'(1);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (W_FIFO_LD+1)'(1);
        2'b01:   cnt_q <= cnt_q - (W_FIFO_LD+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wp_q] <= sel;
  end

  always_comb begin : w_path
    m.wvalid = '0;
    m.wdata  = '0;
    m.wstrb  = '0;
    m.wlast  = '0;
    s.wready = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (w_en && h == PL'(i)) begin
        m.wvalid[0] = s.wvalid[i];
        m.wdata     = s.wdata[i*512 +: 512];
        m.wstrb     = s.wstrb[i*64 +: 64];
        m.wlast[0]  = s.wlast[i];
        s.wready[i] = m.wready[0];
      end
    end
  end

  always_comb begin : b_path
    s.bvalid  = '0;
    // Out-of-range port prefix: accept and drop.
    m.bready  = 1'b1;
    s.bid     = m.bid[ID_W-1:0];
    s.bresp   = m.bresp;
    for (int i = 0; i < N_PORTS; i++) begin
      if (p == PL'(i)) begin
        s.bvalid[i] = m.bvalid[0];
        m.bready[0] = s.bready[i];
      end
    end
  end
endmodule

// File: tb/tb_axis_buf_wr_arb.sv
// Scoreboard bench for axis_buf_wr_arb: directed AW/W/B traffic,
// expected grants, beats and responses queued and checked by monitors.
module tb_axis_buf_wr_arb;
  localparam int N  = 4;
  localparam int PL = 2;
  localparam int IW = 16;
  localparam int AW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axis_buf_wr_arb_if #(.NP(N), .IW(IW), .AW(AW))    s_if ();
  axis_buf_wr_arb_if #(.NP(1), .IW(PL+IW), .AW(AW)) m_if ();

  axis_buf_wr_arb #(
    .N_PORTS(N), .PL(PL), .ID_W(IW), .ADDR_W(AW), .W_FIFO_LD(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s(s_if),
    .m(m_if)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct { int p; logic [63:0] a; } aw_t;
  typedef struct { int p; logic [511:0] d; logic l; } w_t;
  typedef struct { logic [3:0] v; logic [15:0] id; logic [1:0] r; } b_t;

  aw_t awq[$];
  w_t  wq[$];
  b_t  bq[$];

  task automatic chk(string nm, logic [511:0] act, logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic unexp(string nm);
    checks++;
    failures++;
    $display("FAIL %s: handshake with empty expect queue", nm);
  endtask

  function automatic logic [511:0] wd(int pt, int k);
    logic [31:0] t;
    t = 32'hD000_0000 | 32'(pt << 8) | 32'(k);
    return {16{t}};
  endfunction

  task automatic aw(int pt, logic v, logic [63:0] a, logic [7:0] len);
    s_if.awvalid[pt]        = v;
    s_if.awaddr[pt*64 +: 64] = a;
    s_if.awlen[pt*8 +: 8]    = len;
  endtask

  task automatic wb(int pt, logic v, logic [511:0] d, logic l);
    s_if.wvalid[pt]           = v;
    s_if.wdata[pt*512 +: 512] = d;
    s_if.wlast[pt]            = l;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_aw(int pt, logic [63:0] a);
    aw_t e;
    e.p = pt;
    e.a = a;
    awq.push_back(e);
  endtask

  task automatic exp_w(int pt, logic [511:0] d, logic l);
    w_t e;
    e.p = pt;
    e.d = d;
    e.l = l;
    wq.push_back(e);
  endtask

  task automatic exp_b(logic [3:0] v, logic [15:0] id, logic [1:0] r);
    b_t e;
    e.v  = v;
    e.id = id;
    e.r  = r;
    bq.push_back(e);
  endtask

  always @(negedge clk) begin : mon_aw
    aw_t e;
    if (!rst && m_if.awvalid[0] && m_if.awready[0]) begin
      if (awq.size() == 0) unexp("aw");
      else begin
        e = awq.pop_front();
        chk("aw_port", m_if.awid[PL+IW-1:IW], e.p);
        chk("aw_id", m_if.awid[IW-1:0], 16'hA000 + e.p);
        chk("aw_addr", m_if.awaddr, e.a);
        chk("aw_srdy", s_if.awready, 4'b1 << e.p);
      end
    end
  end

  always @(negedge clk) begin : mon_w
    w_t e;
    if (!rst && m_if.wvalid[0] && m_if.wready[0]) begin
      if (wq.size() == 0) unexp("w");
      else begin
        e = wq.pop_front();
        chk("w_data", m_if.wdata, e.d);
        chk("w_last", m_if.wlast, e.l);
        chk("w_srdy", s_if.wready, 4'b1 << e.p);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    b_t e;
    if (!rst && (s_if.bvalid & s_if.bready) != '0) begin
      if (bq.size() == 0) unexp("b");
      else begin
        e = bq.pop_front();
        chk("b_valid", s_if.bvalid, e.v);
        chk("b_id", s_if.bid, e.id);
        chk("b_resp", s_if.bresp, e.r);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    s_if.awvalid = '0;
    s_if.awaddr  = '0;
    s_if.awlen   = '0;
    s_if.awsize  = {N{3'd6}};
    s_if.wvalid  = '0;
    s_if.wdata   = '0;
    s_if.wstrb   = '1;
    s_if.wlast   = '0;
    s_if.bready  = '0;
    for (int i = 0; i < N; i++) s_if.awid[i*16 +: 16] = 16'hA000 + 16'(i);
    m_if.awready = '0;
    m_if.wready  = '0;
    m_if.bvalid  = '0;
    m_if.bid     = '0;
    m_if.bresp   = '0;

    // reset state
    @(negedge clk);
    chk("rst_m_awvalid", m_if.awvalid, 0);
    chk("rst_s_awready", s_if.awready, 0);
    chk("rst_s_wready", s_if.wready, 0);
    chk("rst_m_wvalid", m_if.wvalid, 0);
    chk("rst_s_bvalid", s_if.bvalid, 0);
    chk("rst_m_bready", m_if.bready, 0);
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_m_awvalid", m_if.awvalid, 0);
    step();

    // round-robin 0,1,2,3,0
    m_if.awready = 1'b1;
    m_if.wready  = 1'b1;
    for (int i = 0; i < N; i++) begin
      aw(i, 1'b1, 64'h1000 * (i + 1), 8'd0);
      wb(i, 1'b1, wd(i, 0), 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      exp_aw(i % N, 64'h1000 * ((i % N) + 1));
      exp_w(i % N, wd(i % N, 0), 1'b1);
    end
    repeat (5) step();
    for (int i = 0; i < N; i++) aw(i, 1'b0, 64'h0, 8'd0);
    step();
    step();
    for (int i = 0; i < N; i++) wb(i, 1'b0, '0, 1'b0);

    // W ordering: port 1 (4 beats) before port 3
    aw(1, 1'b1, 64'h2100, 8'd3);
    wb(3, 1'b1, wd(3, 0), 1'b1);
    exp_aw(1, 64'h2100);
    exp_aw(3, 64'h2300);
    step();
    aw(1, 1'b0, 64'h2100, 8'd3);
    aw(3, 1'b1, 64'h2300, 8'd0);
    step();
    aw(3, 1'b0, 64'h2300, 8'd0);
    for (int k = 0; k < 4; k++) begin
      wb(1, 1'b1, wd(1, k), k == 3);
      exp_w(1, wd(1, k), k == 3);
      @(negedge clk);
      chk("worder_p3_wready", s_if.wready[3], 0);
      step();
    end
    exp_w(3, wd(3, 0), 1'b1);
    wb(1, 1'b0, '0, 1'b0);
    step();
    wb(3, 1'b0, '0, 1'b0);
    step();

    // lock hold: port 2 stays granted while port 0 (higher priority) waits
    m_if.awready = 1'b0;
    aw(2, 1'b1, 64'h3200, 8'd0);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) aw(0, 1'b1, 64'h3000, 8'd0);
      @(negedge clk);
      chk("lock_addr", m_if.awaddr, 64'h3200);
      chk("lock_port", m_if.awid[PL+IW-1:IW], 2);
      step();
    end
    exp_aw(2, 64'h3200);
    exp_aw(0, 64'h3000);
    m_if.awready = 1'b1;
    step();
    aw(2, 1'b0, 64'h3200, 8'd0);
    step();
    aw(0, 1'b0, 64'h3000, 8'd0);
    m_if.awready = 1'b0;
    wb(2, 1'b1, wd(2, 0), 1'b1);
    wb(0, 1'b1, wd(0, 0), 1'b1);
    exp_w(2, wd(2, 0), 1'b1);
    exp_w(0, wd(0, 0), 1'b1);
    repeat (3) step();
    wb(2, 1'b0, '0, 1'b0);
    wb(0, 1'b0, '0, 1'b0);

    // FIFO full: 8 bursts outstanding blocks the 9th AW
    m_if.wready  = 1'b0;
    m_if.awready = 1'b1;
    aw(0, 1'b1, 64'h4000, 8'd0);
    repeat (8) begin
      exp_aw(0, 64'h4000);
      step();
    end
    @(negedge clk);
    chk("full_m_awvalid", m_if.awvalid, 0);
    chk("full_s_awready", s_if.awready, 0);
    step();
    wb(0, 1'b1, wd(0, 9), 1'b1);
    m_if.wready = 1'b1;
    exp_w(0, wd(0, 9), 1'b1);
    @(negedge clk);
    chk("full_pop_cycle_awvalid", m_if.awvalid, 0);
    step();
    wb(0, 1'b0, '0, 1'b0);
    m_if.wready = 1'b0;
    @(negedge clk);
    chk("refill_m_awvalid", m_if.awvalid, 1);
    exp_aw(0, 64'h4000);
    step();
    aw(0, 1'b0, 64'h4000, 8'd0);
    wb(0, 1'b1, wd(0, 10), 1'b1);
    m_if.wready = 1'b1;
    repeat (8) begin
      exp_w(0, wd(0, 10), 1'b1);
      step();
    end
    wb(0, 1'b0, '0, 1'b0);
    m_if.awready = 1'b0;
    step();

    // B routing by ID prefix
    m_if.bid    = {2'd3, 16'h00A5};
    m_if.bvalid = 1'b1;
    m_if.bresp  = 2'b00;
    exp_b(4'b1000, 16'h00A5, 2'b00);
    repeat (2) begin
      @(negedge clk);
      chk("b_route_valid", s_if.bvalid, 4'b1000);
      chk("b_route_bid", s_if.bid, 16'h00A5);
      chk("b_route_bready0", m_if.bready, 0);
      step();
    end
    s_if.bready = 4'b1000;
    @(negedge clk);
    chk("b_route_bready1", m_if.bready, 1);
    step();
    m_if.bid    = {2'd1, 16'h0033};
    m_if.bresp  = 2'b10;
    s_if.bready = 4'b1111;
    exp_b(4'b0010, 16'h0033, 2'b10);
    @(negedge clk);
    chk("b_route_p1_valid", s_if.bvalid, 4'b0010);
    step();
    m_if.bvalid = 1'b0;
    s_if.bready = '0;
    step();

    // reset during beat 2 of a 4-beat burst
    m_if.awready = 1'b1;
    m_if.wready  = 1'b1;
    aw(1, 1'b1, 64'h5100, 8'd3);
    exp_aw(1, 64'h5100);
    step();
    aw(1, 1'b0, 64'h5100, 8'd3);
    for (int k = 0; k < 2; k++) begin
      wb(1, 1'b1, wd(1, k), 1'b0);
      exp_w(1, wd(1, k), 1'b0);
      step();
    end
    wb(1, 1'b1, wd(1, 2), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_m_wvalid", m_if.wvalid, 0);
    step();
    rst = 1'b0;
    aw(0, 1'b1, 64'h5000, 8'd0);
    aw(1, 1'b1, 64'h5100, 8'd0);
    aw(2, 1'b1, 64'h5200, 8'd0);
    exp_aw(0, 64'h5000);
    @(negedge clk);
    chk("post_rst_m_wvalid", m_if.wvalid, 0);
    chk("post_rst_grant", m_if.awid[PL+IW-1:IW], 0);
    step();
    for (int i = 0; i < 3; i++) aw(i, 1'b0, 64'h0, 8'd0);
    wb(1, 1'b0, '0, 1'b0);
    wb(0, 1'b1, wd(0, 5), 1'b1);
    exp_w(0, wd(0, 5), 1'b1);
    step();
    wb(0, 1'b0, '0, 1'b0);
    repeat (3) step();

    chk("awq_drained", awq.size(), 0);
    chk("wq_drained", wq.size(), 0);
    chk("bq_drained", bq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
